// File: rtl/sort_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sort_checker_pkg
//  Description : Shared types and constants for the sort checker block.
//  Revision    : 1.0  initial release
// ============================================================================
package sort_checker_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Byte distance between consecutive words in memory
    localparam int C_WORD_STRIDE = 4;

endpackage
`default_nettype wire

// File: rtl/sort_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : sort_checker_if
//  Description : Memory read bus between the sort checker and its memory.
//                Read data is valid exactly one cycle after rd_en.
//  Revision    : 1.0  initial release
// ============================================================================
interface sort_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Read requester (the checker)
    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    // Memory side
    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/sort_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : sort_cmp
//  Description : Neighbour comparator. Flags when cur breaks the requested
//                order relative to prev (ascending/descending, strict or not).
//  Revision    : 1.0  initial release
// ============================================================================
module sort_cmp #(
    parameter int DATA_W     = 32,
    parameter int SIGNED_CMP = 1
) (
    input  wire logic [DATA_W-1:0] prev,
    input  wire logic [DATA_W-1:0] cur,
    input  wire logic              descending,
    input  wire logic              strict,
    output logic                   violation
);

    logic w_lt;
    logic w_eq;
    logic w_gt;

    generate
        if (SIGNED_CMP != 0) begin : g_signed
            assign w_lt = $signed(cur) < $signed(prev);
        end else begin : g_unsigned
            assign w_lt = cur < prev;
        end
    endgenerate

    assign w_eq = (cur == prev);
    assign w_gt = !w_lt && !w_eq;

    // Equal neighbours only break the order when strict ordering is requested
    always_comb begin
        violation = descending ? (w_gt || (strict && w_eq))
                               : (w_lt || (strict && w_eq));
    end

endmodule
`default_nettype wire

// File: rtl/sort_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sort_checker
//  Description : Scans N words from memory and reports whether they are in
//                the requested order, plus the index of the first offender.
//  Revision    : 1.0  initial release
// ============================================================================
module sort_checker
    import sort_checker_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int SIGNED_CMP = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [CNT_W-1:0]  count,
    input  wire logic              descending,
    input  wire logic              strict,
    sort_checker_if.master         bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       fail_idx
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_rx_idx;
    logic [CNT_W-1:0]  r_fail_idx;
    logic [DATA_W-1:0] r_prev;
    logic              r_desc;
    logic              r_strict;
    logic              r_data_vld;
    logic              r_pass;

    logic w_accept;
    logic w_issue;
    logic w_cmp_valid;
    logic w_last_cmp;
    logic w_violation;

    // Start only counts when the block is idle
    assign w_accept    = start && (r_state == IDLE);
    // Keep reading until all N words are requested or the scan ends
    assign w_issue     = (r_state == SCAN) && (r_rd_cnt < r_count);
    // Element 0 has no predecessor, so comparisons begin with element 1
    assign w_cmp_valid = (r_state == SCAN) && r_data_vld && (r_rx_idx != '0);
    assign w_last_cmp  = (r_rx_idx == (r_count - CNT_W'(1)));

    sort_cmp #(
        .DATA_W     (DATA_W),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
        .prev       (r_prev),
        .cur        (bus.rd_data),
        .descending (r_desc),
        .strict     (r_strict),
        .violation  (w_violation)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (count > CNT_W'(1)) ? SCAN : FINISH;
                end
            end
            SCAN: begin
                if (w_cmp_valid && (w_violation || w_last_cmp)) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture scan configuration when a start is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_desc   <= 1'b0;
            r_strict <= 1'b0;
        end else if (w_accept) begin
            r_count  <= count;
            r_desc   <= descending;
            r_strict <= strict;
        end
    end

    // Read address generator; addresses wrap naturally at 2^ADDR_W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_rd_cnt   <= '0;
            r_data_vld <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= base_addr;
            r_rd_cnt   <= '0;
            r_data_vld <= 1'b0;
        end else begin
            r_data_vld <= w_issue;
            if (w_issue) begin
                r_addr   <= r_addr + ADDR_W'(C_WORD_STRIDE);
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
        end
    end

    // Track the previous element and record the scan verdict; data arriving
    // after the verdict (late reads) is ignored because the state has left SCAN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev     <= '0;
            r_rx_idx   <= '0;
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
        end else if (w_accept) begin
            r_rx_idx   <= '0;
            r_pass     <= (count < CNT_W'(2));
            r_fail_idx <= '0;
        end else if ((r_state == SCAN) && r_data_vld) begin
            r_prev   <= bus.rd_data;
            r_rx_idx <= r_rx_idx + CNT_W'(1);
            if (w_cmp_valid) begin
                if (w_violation) begin
                    r_pass     <= 1'b0;
                    r_fail_idx <= r_rx_idx;
                end else if (w_last_cmp) begin
                    r_pass <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_en   = w_issue;
    assign bus.rd_addr = r_addr;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == FINISH);
    assign pass        = r_pass;
    assign fail_idx    = r_fail_idx;

endmodule
`default_nettype wire

// File: tb/tb_sort_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort_checker
//  Description : Bench for sort_checker. A signed and an unsigned instance
//                scan the same memory; results are compared with a reference
//                model that evaluates the ordering rules directly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sort_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] count;
    logic        descending;
    logic        strict;

    logic [1:0]        busy_w;
    logic [1:0]        done_w;
    logic [1:0]        pass_w;
    logic [1:0][15:0]  fidx_w;
    logic [1:0]        rd_en_w;
    logic [1:0][31:0]  addr_w;

    logic [31:0] mem  [0:255];
    logic [31:0] vals [0:63];

    int n_cmp;
    int n_bad;
    int scan_id;

    sort_checker_if #(.ADDR_W(32), .DATA_W(32)) bus_s ();
    sort_checker_if #(.ADDR_W(32), .DATA_W(32)) bus_u ();

    sort_checker #(.DATA_W(32), .ADDR_W(32), .CNT_W(16), .SIGNED_CMP(1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .descending(descending), .strict(strict), .bus(bus_s),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail_idx(fidx_w[0])
    );

    sort_checker #(.DATA_W(32), .ADDR_W(32), .CNT_W(16), .SIGNED_CMP(0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .descending(descending), .strict(strict), .bus(bus_u),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail_idx(fidx_w[1])
    );

    assign rd_en_w[0] = bus_s.rd_en;
    assign rd_en_w[1] = bus_u.rd_en;
    assign addr_w[0]  = bus_s.rd_addr;
    assign addr_w[1]  = bus_u.rd_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, 256 words, byte address bits [9:2]
    always @(posedge clk) begin
        bus_s.rd_data <= mem[bus_s.rd_addr[9:2]];
        bus_u.rd_data <= mem[bus_u.rd_addr[9:2]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint ext(input logic [31:0] v, input bit sgn);
        if (sgn) return longint'($signed(v));
        return longint'({32'b0, v});
    endfunction

    // Ordering rule: does cur break the order relative to prev?
    function automatic bit ref_bad(input logic [31:0] p, input logic [31:0] c,
                                   input bit desc, input bit strict_i, input bit sgn);
        longint a;
        longint b;
        a = ext(p, sgn);
        b = ext(c, sgn);
        if (!desc) return strict_i ? (b <= a) : (b < a);
        return strict_i ? (b >= a) : (b > a);
    endfunction

    task automatic run_scan(input logic [31:0] base, input int n, input bit desc,
                            input bit strict_i, input bit poke);
        int exp_done [2];
        int exp_pass [2];
        int exp_fidx [2];
        int exp_reads[2];
        int got_done [2];
        int got_pass [2];
        int got_fidx [2];
        int reads    [2];
        int addr_err [2];
        int busy_cnt [2];
        int done_cnt [2];
        int k;
        string pfx;

        for (int i = 0; i < n; i++) mem[8'(int'(base[9:2]) + i)] = vals[i];

        for (int j = 0; j < 2; j++) begin
            k = 0;
            for (int i = 1; i < n; i++)
                if (k == 0 && ref_bad(vals[i-1], vals[i], desc, strict_i, j == 0)) k = i;
            if (n < 2) begin
                exp_done[j] = 1; exp_pass[j] = 1; exp_fidx[j] = 0; exp_reads[j] = 0;
            end else if (k != 0) begin
                exp_done[j] = k + 3; exp_pass[j] = 0; exp_fidx[j] = k;
                exp_reads[j] = (k + 2 < n) ? k + 2 : n;
            end else begin
                exp_done[j] = n + 2; exp_pass[j] = 1; exp_fidx[j] = 0; exp_reads[j] = n;
            end
            got_done[j] = 0; got_pass[j] = 0; got_fidx[j] = 0;
            reads[j] = 0; addr_err[j] = 0; busy_cnt[j] = 0; done_cnt[j] = 0;
        end

        base_addr  = base;
        count      = 16'(n);
        descending = desc;
        strict     = strict_i;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        for (int c = 1; c <= n + 6; c++) begin
            for (int j = 0; j < 2; j++) begin
                if (done_w[j]) begin
                    done_cnt[j]++;
                    if (got_done[j] == 0) begin
                        got_done[j] = c;
                        got_pass[j] = int'(pass_w[j]);
                        got_fidx[j] = int'(fidx_w[j]);
                    end
                end
                if (rd_en_w[j]) begin
                    if (addr_w[j] !== base + 32'(4 * reads[j])) addr_err[j]++;
                    reads[j]++;
                end
                if (busy_w[j]) busy_cnt[j]++;
            end
            // A start while busy must have no effect
            if (poke && c == 3) begin
                start = 1'b1; count = 16'd0; base_addr = 32'h0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;

        for (int j = 0; j < 2; j++) begin
            pfx = $sformatf("scan%0d.%s", scan_id, (j == 0) ? "sgn" : "uns");
            check({pfx, ".done_cycle"}, 64'(got_done[j]),  64'(exp_done[j]));
            check({pfx, ".pass"},       64'(got_pass[j]),  64'(exp_pass[j]));
            check({pfx, ".fail_idx"},   64'(got_fidx[j]),  64'(exp_fidx[j]));
            check({pfx, ".reads"},      64'(reads[j]),     64'(exp_reads[j]));
            check({pfx, ".addr_err"},   64'(addr_err[j]),  64'd0);
            check({pfx, ".busy_cyc"},   64'(busy_cnt[j]),  64'(exp_done[j]));
            check({pfx, ".done_cnt"},   64'(done_cnt[j]),  64'd1);
            check({pfx, ".pass_hold"},  64'(pass_w[j]),    64'(exp_pass[j]));
        end
        scan_id++;
    endtask

    task automatic check_all_zero(input string tag);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("%s.%0d.rd_en", tag, j),    64'(rd_en_w[j]), 64'd0);
            check($sformatf("%s.%0d.rd_addr", tag, j),  64'(addr_w[j]),  64'd0);
            check($sformatf("%s.%0d.busy", tag, j),     64'(busy_w[j]),  64'd0);
            check($sformatf("%s.%0d.done", tag, j),     64'(done_w[j]),  64'd0);
            check($sformatf("%s.%0d.pass", tag, j),     64'(pass_w[j]),  64'd0);
            check($sformatf("%s.%0d.fail_idx", tag, j), 64'(fidx_w[j]),  64'd0);
        end
    endtask

    task automatic fill_ramp(input int n, input bit desc);
        for (int i = 0; i < n; i++) vals[i] = desc ? 32'(121 - 11 * i) : 32'(11 * i);
    endtask

    // Assert reset in cycle 6 of a 12-element scan, then verify recovery
    task automatic reset_mid_scan();
        int done_seen;
        fill_ramp(12, 1'b0);
        for (int i = 0; i < 12; i++) mem[8'(128 + i)] = vals[i];
        base_addr = 32'd512; count = 16'd12; descending = 1'b0; strict = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1 check_all_zero("rst_mid");
        done_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done_w != 2'b00 || busy_w != 2'b00) done_seen++;
        end
        check("rst_mid.no_done", 64'(done_seen), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_scan(32'd512, 12, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int          n;
        bit          d;
        n_cmp = 0; n_bad = 0; scan_id = 0;
        rst = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        descending = 1'b0; strict = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Sorted ramp, ascending strict
        fill_ramp(12, 1'b0);
        run_scan(32'd512, 12, 1'b0, 1'b1, 1'b0);

        // Early violation at element 2
        vals[0] = 55; vals[1] = 88; vals[2] = 0;
        for (int i = 3; i < 12; i++) vals[i] = 32'(11 * (i - 1));
        run_scan(32'd512, 12, 1'b0, 1'b1, 1'b0);

        // Equal neighbours, non-strict then strict
        vals[0] = 5; vals[1] = 5; vals[2] = 7;
        run_scan(32'd512, 3, 1'b0, 1'b0, 1'b0);
        run_scan(32'd512, 3, 1'b0, 1'b1, 1'b0);

        // Signed versus unsigned interpretation
        vals[0] = 32'hFFFF_FFFF; vals[1] = 32'd1;
        run_scan(32'd512, 2, 1'b0, 1'b1, 1'b0);

        // Descending ramp, then degenerate lengths
        fill_ramp(12, 1'b1);
        run_scan(32'd512, 12, 1'b1, 1'b1, 1'b0);
        run_scan(32'd512, 1, 1'b1, 1'b1, 1'b0);
        run_scan(32'd512, 0, 1'b1, 1'b1, 1'b0);

        // Start pulsed while busy must be ignored
        fill_ramp(12, 1'b0);
        run_scan(32'd512, 12, 1'b0, 1'b1, 1'b1);

        // Address wrap across 2^32
        fill_ramp(6, 1'b0);
        run_scan(32'hFFFF_FFF8, 6, 1'b0, 1'b0, 1'b0);

        reset_mid_scan();

        // Random scans: mostly ordered runs with occasional jumps
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(0, 20);
            d = 1'($urandom_range(0, 1));
            v = $urandom;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) v = $urandom;
                else if (d) v = v - 32'($urandom_range(0, 2));
                else v = v + 32'($urandom_range(0, 2));
                vals[i] = v;
            end
            run_scan($urandom & 32'hFFFF_FFFC, n, d, 1'($urandom_range(0, 1)),
                     (n >= 2) && ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sort_checker.md
SORT_CHECKER -- requirements
Module: sort_checker

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter CNT_W, default 16, width of element-count input.
REQ-004 Parameter SIGNED_CMP, default 1, selects two's-complement (1) or unsigned (0) comparison.
REQ-005 Port clk  in  1  single clock, all state updates on rising edge.
REQ-006 Port rst  in  1  reset, asynchronous assert, active-low.
REQ-007 Port start  in  1  one-cycle request to begin a scan.
REQ-008 Port base_addr  in  ADDR_W  byte address of element 0, sampled with start.
REQ-009 Port count  in  CNT_W  number of elements N, sampled with start.
REQ-010 Port descending  in  1  0 = ascending order required, 1 = descending, sampled with start.
REQ-011 Port strict  in  1  1 = equal neighbours violate order, 0 = equal allowed, sampled with start.
REQ-012 Port rd_en  out  1  memory read request.
REQ-013 Port rd_addr  out  ADDR_W  word-aligned byte read address.
REQ-014 Port rd_data  in  DATA_W  read data, valid exactly one cycle after rd_en.
REQ-015 Port busy  out  1  scan in progress.
REQ-016 Port done  out  1  one-cycle pulse at scan completion.
REQ-017 Port pass  out  1  result of last scan, held until next accepted start.
REQ-018 Port fail_idx  out  CNT_W  index k of first element violating order against element k-1, 0 on pass.

Function
REQ-019 States SHALL be IDLE, SCAN, FINISH; IDLE->SCAN on start with N>=2; IDLE->FINISH on start with N<2; SCAN->FINISH on last compare or first violation; FINISH->IDLE unconditionally.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 Cycle 1 = first cycle after the edge sampling start; in SCAN, rd_en SHALL be high in cycles 1..N with rd_addr = base_addr + 4*(cycle-1), wrapping modulo 2^ADDR_W.
REQ-022 Element k data (cycle k+2) SHALL be compared with registered element k-1 for k>=1; the result is registered at the end of cycle k+2.
REQ-023 Violation: ascending strict a[k]<=a[k-1]; ascending non-strict a[k]<a[k-1]; descending mirrored.
REQ-024 On violation at k, rd_en SHALL drop from cycle k+3 on, done SHALL pulse in cycle k+3, pass=0, fail_idx=k.
REQ-025 Without violation, done SHALL pulse in cycle N+2 with pass=1, fail_idx=0.
REQ-026 N=0 or N=1: no reads, done in cycle 1, pass=1.
REQ-027 busy SHALL be high from cycle 1 through the done cycle inclusive.
REQ-028 Late reads issued before a violation is registered are permitted; their data SHALL be discarded.

Reset
REQ-029 rst low SHALL immediately force IDLE, rd_en=0, rd_addr=0, busy=0, done=0, pass=0, fail_idx=0.
REQ-030 Reset mid-scan SHALL abort without a done pulse; first start after release behaves as from power-up.

Structure
REQ-031 Package sort_checker_pkg SHALL hold the state enum and the word stride constant (4).
REQ-032 Comparator SHALL be sub-module sort_cmp (inputs prev, cur, descending, strict; output violation; parameters DATA_W, SIGNED_CMP).

Verification
REQ-033 Memory at 512.. = 0,11,22,33,44,55,66,77,88,99,110,121; start base=512 N=12 asc strict -> done cycle 14, pass=1, fail_idx=0, 12 reads.
REQ-034 Memory at 512.. = 55,88,0,22,...; same start -> done cycle 5, pass=0, fail_idx=2, rd_en low from cycle 5.
REQ-035 Values 5,5,7 N=3: strict=0 -> pass=1; strict=1 -> pass=0, fail_idx=1.
REQ-036 Values -1,1 (0xFFFFFFFF,1) asc N=2: SIGNED_CMP=1 -> pass=1; SIGNED_CMP=0 -> pass=0, fail_idx=1.
REQ-037 Descending 121,110,...,0 N=12 -> pass=1; N=1 and N=0 -> done cycle 1, pass=1, rd_en never high.
REQ-038 rst low in cycle 6 of a 12-element scan -> all outputs 0 at once, no done; new start completes normally; start pulsed while busy is ignored.
